// File: rtl/bcd_counter_mod_if.sv
`default_nettype none
// ============================================================================
// Module     : bcd_counter_mod_if
// Description: Control/data bundle for the multi-digit BCD counter. The
//              master drives enable, direction, load and load data. The
//              slave (the counter) returns the count, terminal count and
//              load-error flag.
// Revision   : 1.0 - initial release
// ============================================================================
interface bcd_counter_mod_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  EN;
  logic                  UP;
  logic                  LD;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   Q;
  logic                  C;
  logic                  ERR;

  modport master (
    output EN, UP, LD, D,
    input  Q, C, ERR
  );

  modport slave (
    input  EN, UP, LD, D,
    output Q, C, ERR
  );
endinterface
`default_nettype wire

// File: rtl/bcd_counter_mod.sv
`default_nettype none
// ============================================================================
// Module     : bcd_counter_mod
// Description: Parametrised multi-digit BCD counter with programmable
//              modulus, up/down counting, count enable, validated
//              synchronous parallel load and a combinational terminal-count
//              flag suitable for cascading.
// Revision   : 1.0 - initial release
// ============================================================================
module bcd_counter_mod #(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned MODULUS = 200
) (
  input  wire logic         Clk,
  input  wire logic         MR,
  bcd_counter_mod_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  // Packed-BCD form of a decimal value; used only on constants.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    int unsigned t;
    logic [W-1:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Largest count in the sequence, in packed BCD.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0]      q_r;
  logic              err_r;
  logic [W-1:0]      q_inc;
  logic [W-1:0]      q_dec;
  logic [DIGITS-1:0] inc_carry;
  logic [DIGITS-1:0] dec_borrow;
  logic [DIGITS-1:0] digit_ok;
  logic              load_ok;
  logic              at_max;
  logic              at_zero;

  assign inc_carry[0]  = 1'b1;
  assign dec_borrow[0] = 1'b1;

  // Per-digit BCD increment/decrement with a ripple carry/borrow chain.
  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    logic [3:0] qd;
    logic [3:0] dd;
    assign qd = q_r[4*i +: 4];
    assign dd = bus.D[4*i +: 4];

    assign q_inc[4*i +: 4] = !inc_carry[i]  ? qd :
                             (qd == 4'd9)   ? 4'd0 : qd + 4'd1;
    assign q_dec[4*i +: 4] = !dec_borrow[i] ? qd :
                             (qd == 4'd0)   ? 4'd9 : qd - 4'd1;
    assign digit_ok[i]     = (dd <= 4'd9);

    if (i < int'(DIGITS) - 1) begin : g_chain
      assign inc_carry[i+1]  = inc_carry[i]  & (qd == 4'd9);
      assign dec_borrow[i+1] = dec_borrow[i] & (qd == 4'd0);
    end
  end

  // With every digit valid, packed-BCD ordering equals decimal ordering,
  // so the range check can compare against the BCD constant directly.
  assign load_ok = (&digit_ok) && (bus.D <= MAX_BCD);
  assign at_max  = (q_r == MAX_BCD);
  assign at_zero = (q_r == '0);

  // Count state and load-error flag: load beats count beats hold.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else if (bus.LD) begin
      if (load_ok) begin
        q_r   <= bus.D;
        err_r <= 1'b0;
      end else begin
        q_r   <= '0;
        err_r <= 1'b1;
      end
    end else begin
      err_r <= 1'b0;
      if (bus.EN) begin
        if (bus.UP) q_r <= at_max  ? '0      : q_inc;
        else        q_r <= at_zero ? MAX_BCD : q_dec;
      end
    end
  end

  assign bus.Q   = q_r;
  assign bus.ERR = err_r;
  // Terminal count is asserted in the cycle before the wrap so a following
  // stage can use it directly as its enable.
  assign bus.C   = bus.EN & ~bus.LD & (bus.UP ? at_max : at_zero);

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_mod.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module     : tb_bcd_counter_mod
// Description: Self-checking bench for bcd_counter_mod (3 digits, mod 200)
//              plus a cascaded pair of single-digit mod-10 stages.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_mod;

  localparam int DIG = 3;
  localparam int MOD = 200;

  logic Clk = 1'b0;
  logic MR  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // Reference state: plain integers
  int   model = 0;
  int   err_m = 0;
  int   casc  = 0;

  always #1 Clk = ~Clk;

  bcd_counter_mod_if #(.DIGITS(DIG)) bus ();
  bcd_counter_mod_if #(.DIGITS(1))   lo_bus ();
  bcd_counter_mod_if #(.DIGITS(1))   hi_bus ();

  bcd_counter_mod #(.DIGITS(DIG), .MODULUS(MOD)) dut (
    .Clk (Clk), .MR (MR), .bus (bus.slave));
  bcd_counter_mod #(.DIGITS(1), .MODULUS(10)) u_lo (
    .Clk (Clk), .MR (MR), .bus (lo_bus.slave));
  bcd_counter_mod #(.DIGITS(1), .MODULUS(10)) u_hi (
    .Clk (Clk), .MR (MR), .bus (hi_bus.slave));

  assign hi_bus.EN = lo_bus.C;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // -1 when the load word is not a legal count
  function automatic int load_value(input logic [4*DIG-1:0] d);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int k = 0; k < DIG; k++) begin
      if (d[4*k +: 4] > 4'd9) return -1;
      v = v + int'(d[4*k +: 4]) * w;
      w = w * 10;
    end
    return (v < MOD) ? v : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: check C before the edge, then Q/ERR/cascade after it.
  task automatic step();
    int exp_c;
    int lv;
    #0.1;
    exp_c = (bus.EN && !bus.LD && (bus.UP ? (model == MOD-1) : (model == 0))) ? 1 : 0;
    check("C", {31'b0, bus.C}, exp_c);
    @(posedge Clk);
    if (bus.LD) begin
      lv = load_value(bus.D);
      if (lv >= 0) begin model = lv; err_m = 0; end
      else         begin model = 0;  err_m = 1; end
    end else begin
      err_m = 0;
      if (bus.EN) model = bus.UP ? (model + 1) % MOD : (model + MOD - 1) % MOD;
    end
    casc = (casc + 1) % 100;
    #0.5;
    check("Q", {20'b0, bus.Q}, to_bcd(model));
    check("ERR", {31'b0, bus.ERR}, err_m);
    check("cascade", {24'b0, hi_bus.Q, lo_bus.Q}, to_bcd(casc));
  endtask

  task automatic drive(input logic en, input logic up, input logic ld, input logic [4*DIG-1:0] d);
    bus.EN = en;
    bus.UP = up;
    bus.LD = ld;
    bus.D  = d;
  endtask

  // Directed sequence followed by randomized traffic
  initial begin
    logic [4*DIG-1:0] rd;
    drive(1'b1, 1'b1, 1'b0, '0);
    lo_bus.EN = 1'b1; lo_bus.UP = 1'b1; lo_bus.LD = 1'b0; lo_bus.D = '0;
    hi_bus.UP = 1'b1; hi_bus.LD = 1'b0; hi_bus.D = '0;

    // Reset held with the clock running
    #10;
    check("rst_Q", {20'b0, bus.Q}, 32'h0);
    check("rst_ERR", {31'b0, bus.ERR}, 32'h0);
    #90;
    check("rst_Q_late", {20'b0, bus.Q}, 32'h0);
    MR = 1'b1;

    // Count up from release: 001 after edge 1, 010 after edge 10
    step();
    check("first_edge", {20'b0, bus.Q}, 32'h001);
    for (int i = 0; i < 9; i++) step();
    check("carry10", {20'b0, bus.Q}, 32'h010);

    // Full up cycle from 000 including the 199 -> 000 wrap
    drive(1'b1, 1'b1, 1'b1, 12'h000);
    step();
    drive(1'b1, 1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 200; i++) step();
    check("wrap_up", {20'b0, bus.Q}, 32'h000);

    // Down from 000 wraps to 199, then 198; 100 -> 099
    drive(1'b1, 1'b0, 1'b0, 12'h000);
    step();
    check("wrap_dn", {20'b0, bus.Q}, 32'h199);
    step();
    check("dn_198", {20'b0, bus.Q}, 32'h198);
    drive(1'b1, 1'b0, 1'b1, 12'h100);
    step();
    drive(1'b1, 1'b0, 1'b0, 12'h000);
    step();
    check("borrow2", {20'b0, bus.Q}, 32'h099);

    // Loads: valid, non-BCD digit, out of range
    drive(1'b1, 1'b1, 1'b1, 12'h157);
    step();
    drive(1'b1, 1'b1, 1'b1, 12'h1A3);
    step();
    drive(1'b1, 1'b1, 1'b0, 12'h000);
    step();
    drive(1'b1, 1'b0, 1'b1, 12'h250);
    step();
    drive(1'b1, 1'b1, 1'b1, 12'h199);
    step();

    // Hold at 042
    drive(1'b0, 1'b1, 1'b1, 12'h042);
    step();
    drive(1'b0, 1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 10; i++) step();
    check("hold", {20'b0, bus.Q}, 32'h042);

    // Asynchronous reset between edges at 123
    drive(1'b1, 1'b1, 1'b1, 12'h123);
    step();
    drive(1'b1, 1'b1, 1'b0, 12'h000);
    #0.3;
    MR = 1'b0;
    #0.1;
    check("async_Q", {20'b0, bus.Q}, 32'h0);
    check("async_casc", {24'b0, hi_bus.Q, lo_bus.Q}, 32'h0);
    model = 0; err_m = 0; casc = 0;
    @(posedge Clk);
    #0.5;
    check("no_count_in_rst", {20'b0, bus.Q}, 32'h0);
    @(negedge Clk);
    MR = 1'b1;

    // Randomized traffic against the integer model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1) == 0) begin
        for (int k = 0; k < DIG; k++) rd[4*k +: 4] = 4'($urandom_range(9));
      end else begin
        rd = 12'($urandom);
      end
      drive(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(7) == 0), rd);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
